// File: rtl/sram_axi_bridge_pkg.sv
// Shared constants for the SRAM-to-AXI bridge: FSM state encoding,
// transaction owner IDs and SRAM size codes.
package sram_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_e;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_axi_bridge.sv
// Arbitrates fetch and data SRAM-like requests onto one single-beat AXI master,
// one transaction in flight; data requests win over fetches in the same cycle.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [3:0]        data_wstrb,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic              rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // a master holds valid and payload steady until that edge, and the bridge
  // treats req/addr_ok on the SRAM side the same way.

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              inst_data_ok_q, inst_data_ok_d;
  logic              data_data_ok_q, data_data_ok_d;

  // Only one transaction is ever outstanding, so rid carries no routing info.
  logic unused_rid;
  assign unused_rid = rid;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    size_d         = size_q;
    wstrb_d        = wstrb_q;
    wdata_d        = wdata_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    inst_rdata_d   = inst_rdata_q;
    data_rdata_d   = data_rdata_q;
    inst_data_ok_d = 1'b0;
    data_data_ok_d = 1'b0;
    inst_addr_ok   = 1'b0;
    data_addr_ok   = 1'b0;
    arvalid        = 1'b0;
    rready         = 1'b0;
    awvalid        = 1'b0;
    wvalid         = 1'b0;
    bready         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_req) begin
          data_addr_ok = 1'b1;
          owner_d      = ID_DATA;
          addr_d       = data_addr;
          size_d       = data_size;
          wstrb_d      = data_wstrb;
          wdata_d      = data_wdata;
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          state_d      = data_wr ? ST_WR_REQ : ST_RD_ADDR;
        end else if (inst_req) begin
          inst_addr_ok = 1'b1;
          owner_d      = ID_INST;
          addr_d       = inst_addr;
          size_d       = SIZE_WORD;
          state_d      = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          if (owner_q == ID_DATA) begin
            data_rdata_d   = rdata;
            data_data_ok_d = 1'b1;
          end else begin
            inst_rdata_d   = rdata;
            inst_data_ok_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        // Address and data channels complete independently, in either order.
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          data_data_ok_d = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      owner_q        <= ID_INST;
      addr_q         <= '0;
      size_q         <= '0;
      wstrb_q        <= '0;
      wdata_q        <= '0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      inst_rdata_q   <= '0;
      data_rdata_q   <= '0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      addr_q         <= addr_d;
      size_q         <= size_d;
      wstrb_q        <= wstrb_d;
      wdata_q        <= wdata_d;
      aw_done_q      <= aw_done_d;
      w_done_q       <= w_done_d;
      inst_rdata_q   <= inst_rdata_d;
      data_rdata_q   <= data_rdata_d;
      inst_data_ok_q <= inst_data_ok_d;
      data_data_ok_q <= data_data_ok_d;
    end
  end

  assign arid         = owner_q;
  assign araddr       = addr_q;
  assign arsize       = {1'b0, size_q};
  assign awaddr       = addr_q;
  assign awsize       = {1'b0, size_q};
  assign wdata        = wdata_q;
  assign wstrb        = wstrb_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;
  assign inst_data_ok = inst_data_ok_q;
  assign data_data_ok = data_data_ok_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: the bench plays both SRAM requesters and the AXI
// slave, and checks every cycle against a transaction-level expectation.
module tb_sram_axi_bridge;
  import sram_axi_bridge_pkg::*;

  logic        clk, reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        arid, arvalid, arready, rid, rvalid, rready;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize, dbg_state;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_inst_rd = '0;
  logic [31:0] exp_data_rd = '0;

  sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // One complete SRAM transaction with a scripted AXI slave. Entered and left
  // just after a negedge in a cycle where the bridge is IDLE.
  task automatic do_txn(input bit is_data, input bit wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int d_ar, input int d_r, input int d_aw,
                        input int d_w, input int d_b);
    logic [2:0] exp_size;
    logic [1:0] exp_ok;
    int n;
    exp_size = is_data ? {1'b0, size} : 3'd2;
    exp_ok   = is_data ? 2'b01 : 2'b10;
    n_checks++;
    if (inst_rdata !== exp_inst_rd || data_rdata !== exp_data_rd) begin
      n_fail++;
      $display("FAIL rdata_hold: inst=%h data=%h required inst=%h data=%h",
               inst_rdata, data_rdata, exp_inst_rd, exp_data_rd);
    end
    if (is_data) begin
      data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr;
      data_wstrb = strb; data_wdata = wd;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    #1;
    n_checks++;
    if ({inst_addr_ok, data_addr_ok} !== exp_ok) begin
      n_fail++;
      $display("FAIL addr_ok: {inst,data}=%b required %b", {inst_addr_ok, data_addr_ok}, exp_ok);
    end
    @(negedge clk);
    // Fields are only sampled on acceptance; scramble them afterwards.
    if (is_data) begin
      data_req = 1'b0; data_addr = $urandom; data_wdata = $urandom;
      data_wstrb = 4'($urandom); data_size = 2'($urandom_range(0, 2));
    end else begin
      inst_req = 1'b0; inst_addr = $urandom;
    end
    if (!(is_data && wr)) begin
      for (int i = 0; i <= d_ar; i++) begin
        #1;
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== addr || arsize !== exp_size || arid !== is_data ||
            rready !== 1'b0 || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
          n_fail++;
          $display("FAIL ar_phase: arvalid=%b araddr=%h arsize=%0d arid=%b rready=%b addr_ok=%b%b required 1 %h %0d %b 0 00",
                   arvalid, araddr, arsize, arid, rready, inst_addr_ok, data_addr_ok, addr, exp_size, is_data);
        end
        arready = (i == d_ar);
        @(negedge clk);
        arready = 1'b0;
      end
      for (int i = 0; i <= d_r; i++) begin
        #1;
        n_checks++;
        if (rready !== 1'b1 || arvalid !== 1'b0 || inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
          n_fail++;
          $display("FAIL r_phase: rready=%b arvalid=%b data_ok=%b%b required 1 0 00",
                   rready, arvalid, inst_data_ok, data_data_ok);
        end
        if (i == d_r) begin rvalid = 1'b1; rdata = rd; end
        @(negedge clk);
        rvalid = 1'b0; rdata = $urandom;
      end
      if (is_data) exp_data_rd = rd; else exp_inst_rd = rd;
    end else begin
      n = (d_aw > d_w) ? d_aw : d_w;
      for (int i = 0; i <= n; i++) begin
        #1;
        n_checks++;
        if (awvalid !== (i <= d_aw) || wvalid !== (i <= d_w) || awaddr !== addr ||
            awsize !== exp_size || wdata !== wd || wstrb !== strb ||
            bready !== 1'b0 || arvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL w_phase cyc %0d: awvalid=%b wvalid=%b awaddr=%h awsize=%0d wdata=%h wstrb=%b required %b %b %h %0d %h %b",
                   i, awvalid, wvalid, awaddr, awsize, wdata, wstrb,
                   (i <= d_aw), (i <= d_w), addr, exp_size, wd, strb);
        end
        awready = (i == d_aw);
        wready  = (i == d_w);
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
      end
      for (int i = 0; i <= d_b; i++) begin
        #1;
        n_checks++;
        if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0 ||
            inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
          n_fail++;
          $display("FAIL b_phase: bready=%b awvalid=%b wvalid=%b data_ok=%b%b required 1 0 0 00",
                   bready, awvalid, wvalid, inst_data_ok, data_data_ok);
        end
        bvalid = (i == d_b);
        @(negedge clk);
        bvalid = 1'b0;
      end
    end
    #1;
    n_checks++;
    if ({inst_data_ok, data_data_ok} !== exp_ok || inst_rdata !== exp_inst_rd ||
        data_rdata !== exp_data_rd || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL data_ok: ok=%b inst_rdata=%h data_rdata=%h state=%0d required %b %h %h %0d",
               {inst_data_ok, data_data_ok}, inst_rdata, data_rdata, dbg_state,
               exp_ok, exp_inst_rd, exp_data_rd, ST_IDLE);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, arvalid, rready,
         awvalid, wvalid, bready} !== 9'b0 || araddr !== 32'h0 || awaddr !== 32'h0 ||
        wdata !== 32'h0 || wstrb !== 4'h0 || inst_rdata !== 32'h0 ||
        data_rdata !== 32'h0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL %s: ctl=%b araddr=%h awaddr=%h wdata=%h wstrb=%b rdata=%h/%h state=%0d required all zero, IDLE",
               name, {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, arvalid,
               rready, awvalid, wvalid, bready}, araddr, awaddr, wdata, wstrb,
               inst_rdata, data_rdata, dbg_state);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
  endtask

  task automatic test_inst_fetch();
    do_txn(0, 0, 2'd0, 32'hBFC0_0000, 4'h0, 32'h0, 32'h3C1D_0040, 2, 3, 0, 0, 0);
    @(negedge clk);
    #1;
    n_checks++;
    if (inst_data_ok !== 1'b0 || inst_rdata !== 32'h3C1D_0040) begin
      n_fail++;
      $display("FAIL inst_ok_width: inst_data_ok=%b inst_rdata=%h required 0 3c1d0040",
               inst_data_ok, inst_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0004;
    do_txn(1, 0, 2'd2, 32'h8000_1004, 4'h0, 32'h0, 32'hA5A5_0001, 1, 1, 0, 0, 0);
    // Held fetch must be picked up in the data_ok cycle, not before.
    n_checks++;
    if (inst_addr_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL contention_inst_accept: inst_addr_ok=%b required 1", inst_addr_ok);
    end
    do_txn(0, 0, 2'd0, 32'hBFC0_0004, 4'h0, 32'h0, 32'h2408_0001, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_store_byte();
    do_txn(1, 1, 2'd0, 32'h8000_0003, 4'b1000, 32'h5555_5555, 32'h0, 0, 0, 2, 0, 1);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_txn(0, 0, 2'd0, 32'hBFC0_0100, 4'h0, 32'h0, 32'h0000_BEEF, 10, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_txn(1, 0, 2'd2, 32'h8000_2000, 4'h0, 32'h0, 32'h1111_1111, 0, 1, 0, 0, 0);
    do_txn(1, 0, 2'd2, 32'h8000_2004, 4'h0, 32'h0, 32'h2222_2222, 0, 1, 0, 0, 0);
    do_txn(1, 1, 2'd1, 32'h8000_2006, 4'b1100, 32'hCAFE_0000, 32'h0, 0, 0, 1, 1, 0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_3000;
    @(negedge clk);
    data_req = 1'b0;
    arready  = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    #1;
    n_checks++;
    if (rready !== 1'b1 || dbg_state !== ST_RD_DATA) begin
      n_fail++;
      $display("FAIL reset_mid_setup: rready=%b state=%0d required 1 %0d", rready, dbg_state, ST_RD_DATA);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_inst_rd = '0;
    exp_data_rd = '0;
    #1;
    check_all_zero("reset_mid");
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    n_checks++;
    if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || data_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL late_rvalid: data_ok=%b%b data_rdata=%h required 00 0",
               inst_data_ok, data_data_ok, data_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      bit is_data, wr;
      is_data = 1'($urandom_range(0, 1));
      wr      = 1'($urandom_range(0, 1));
      do_txn(is_data, wr, 2'($urandom_range(0, 2)), $urandom, 4'($urandom), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0;
    data_wstrb = '0; data_wdata = '0;
    arready = 1'b0; rid = 1'b0; rdata = '0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    @(negedge clk);
    test_reset();
    test_inst_fetch();
    test_contention();
    test_store_byte();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
